// File: rtl/button_event_pkg.sv
// Shared encodings for the button event generator: FSM state codes, event kinds
// and the default event bytes.
package button_event_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PRESS     = 2'd1;
   localparam logic [1:0] ST_LONG_HELD = 2'd2;

   typedef enum logic [1:0] {
      EV_SHORT = 2'd0,
      EV_LONG  = 2'd1,
      EV_REL   = 2'd2,
      EV_REP   = 2'd3
   } ev_kind_t;

   localparam logic [7:0] DEF_SHORT_CODE = 8'h53;
   localparam logic [7:0] DEF_LONG_CODE  = 8'h4C;
   localparam logic [7:0] DEF_REL_CODE   = 8'h52;
   localparam logic [7:0] DEF_REP_CODE   = 8'h50;

   function automatic int ms_cnt_width(input int long_ticks, input int repeat_ticks);
      int m;
      m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_event_gen_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Shared with the debouncer, so it is never cleared except by reset.
module tick_prescaler #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tick = (count_reg == LAST);

endmodule

// File: rtl/button_event_gen.sv
// Turns the debounced button level into short/long/release event bytes on a
// one-entry valid/ready slot. Define BUTTON_AUTOREPEAT_EN for repeat events while held.
module button_event_gen
   import button_event_pkg::*;
#(
   parameter int          TICK_DIV     = 100000,
   parameter int          LONG_TICKS   = 500,
   parameter int          REPEAT_TICKS = 200,
   parameter logic [7:0]  SHORT_CODE   = DEF_SHORT_CODE,
   parameter logic [7:0]  LONG_CODE    = DEF_LONG_CODE,
   parameter logic [7:0]  REL_CODE     = DEF_REL_CODE,
   parameter logic [7:0]  REP_CODE     = DEF_REP_CODE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       debounced,
   output logic [7:0] ev_data,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       ev_drop,
   output logic       busy
);

   localparam int MS_W = ms_cnt_width(LONG_TICKS, REPEAT_TICKS);

   logic            tick;
   logic [1:0]      state_reg, state_next;
   logic [MS_W-1:0] ms_cnt_reg;
   logic            cnt_clear;
   logic            emit;
   ev_kind_t        emit_kind;
   logic [7:0]      emit_code;
   logic [7:0]      ev_data_reg;
   logic            ev_valid_reg;
   logic            ev_drop_reg;
   logic            slot_load;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // Release is tested first in every held state so it wins over a coincident tick.
   always_comb begin
      state_next = state_reg;
      emit       = 1'b0;
      emit_kind  = EV_SHORT;
      cnt_clear  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (debounced) begin
               state_next = ST_PRESS;
               cnt_clear  = 1'b1;
            end
         end
         ST_PRESS: begin
            if (!debounced) begin
               emit       = 1'b1;
               emit_kind  = EV_SHORT;
               state_next = ST_IDLE;
               cnt_clear  = 1'b1;
            end else if (tick && ms_cnt_reg == MS_W'(LONG_TICKS - 1)) begin
               emit       = 1'b1;
               emit_kind  = EV_LONG;
               state_next = ST_LONG_HELD;
               cnt_clear  = 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (!debounced) begin
               emit       = 1'b1;
               emit_kind  = EV_REL;
               state_next = ST_IDLE;
               cnt_clear  = 1'b1;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            else if (tick && ms_cnt_reg == MS_W'(REPEAT_TICKS - 1)) begin
               emit       = 1'b1;
               emit_kind  = EV_REP;
               cnt_clear  = 1'b1;
            end
`endif
         end
         default: begin
            state_next = ST_IDLE;
            cnt_clear  = 1'b1;
         end
      endcase
   end

   always_comb begin
      emit_code = SHORT_CODE;
      case (emit_kind)
         EV_SHORT: emit_code = SHORT_CODE;
         EV_LONG:  emit_code = LONG_CODE;
         EV_REL:   emit_code = REL_CODE;
         EV_REP:   emit_code = REP_CODE;
         default:  emit_code = SHORT_CODE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ST_IDLE;
         ms_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (cnt_clear) begin
            ms_cnt_reg <= '0;
         end else if (tick && ms_cnt_reg != {MS_W{1'b1}}) begin
            ms_cnt_reg <= ms_cnt_reg + 1'b1;
         end
      end
   end

   // The slot accepts a new event when empty or when its current one is leaving.
   assign slot_load = emit && (!ev_valid_reg || ev_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ev_valid_reg <= 1'b0;
         ev_data_reg  <= 8'h00;
         ev_drop_reg  <= 1'b0;
      end else begin
         ev_drop_reg <= emit && ev_valid_reg && !ev_ready;
         if (slot_load) begin
            ev_valid_reg <= 1'b1;
            ev_data_reg  <= emit_code;
         end else if (ev_valid_reg && ev_ready) begin
            ev_valid_reg <= 1'b0;
         end
      end
   end

   assign ev_data  = ev_data_reg;
   assign ev_valid = ev_valid_reg;
   assign ev_drop  = ev_drop_reg;
   assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized and directed bench for button_event_gen against a press-duration
// model that counts ticks and queues events at the behavioural level.
module tb_button_event_gen;

   localparam int TICK_DIV     = 4;
   localparam int LONG_TICKS   = 5;
   localparam int REPEAT_TICKS = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       debounced;
   logic [7:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_drop;
   logic       busy;

   button_event_gen #(
      .TICK_DIV     (TICK_DIV),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .debounced (debounced),
      .ev_data   (ev_data),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_drop   (ev_drop),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Model: elapsed-cycle phase gives the tick, press length is counted in ticks.
   int         m_k;
   bit         m_pressed, m_long, m_tick, m_emit, m_valid, m_drop;
   int         m_ticks;
   logic [7:0] m_code, m_data;

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_k = 0; m_pressed = 0; m_long = 0; m_ticks = 0;
            m_valid = 0; m_data = 8'h00; m_drop = 0;
         end else begin
            m_tick = ((m_k % TICK_DIV) == TICK_DIV - 1);
            m_k++;
            m_emit = 0;
            if (!m_pressed) begin
               if (debounced) begin
                  m_pressed = 1; m_long = 0; m_ticks = 0;
               end
            end else if (!debounced) begin
               m_emit = 1;
               m_code = m_long ? 8'h52 : 8'h53;
               m_pressed = 0;
            end else if (m_tick) begin
               m_ticks++;
               if (!m_long && m_ticks == LONG_TICKS) begin
                  m_emit = 1; m_code = 8'h4C; m_long = 1; m_ticks = 0;
               end
`ifdef BUTTON_AUTOREPEAT_EN
               else if (m_long && m_ticks == REPEAT_TICKS) begin
                  m_emit = 1; m_code = 8'h50; m_ticks = 0;
               end
`endif
            end
            m_drop = 0;
            if (m_emit && (!m_valid || ev_ready)) begin
               m_valid = 1; m_data = m_code;
            end else if (m_emit) begin
               m_drop = 1;
            end else if (m_valid && ev_ready) begin
               m_valid = 0;
            end
         end
      end
   end

   int         cyc = 0;
   logic [7:0] log_q[$];
   int         stamp_q[$];
   int         valid_cycles;
   int         drop_count;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            check("valid", int'(ev_valid), int'(m_valid));
            check("data", int'(ev_data), int'(m_data));
            check("drop", int'(ev_drop), int'(m_drop));
            check("busy", int'(busy), int'(m_pressed));
            if (ev_valid) valid_cycles++;
            if (ev_drop) drop_count++;
            if (ev_valid && ev_ready) begin
               log_q.push_back(ev_data);
               stamp_q.push_back(cyc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_q.delete();
      stamp_q.delete();
      valid_cycles = 0;
      drop_count = 0;
   endtask

   initial begin
      bit found;
      int n_rep, n_short;
      reset_n = 1'b0; debounced = 1'b0; ev_ready = 1'b0;
      clear_log();
      step(3);
      check("rst_valid", int'(ev_valid), 0);
      check("rst_data", int'(ev_data), 0);
      check("rst_drop", int'(ev_drop), 0);
      check("rst_busy", int'(busy), 0);
      reset_n = 1'b1;

      // 1: short press
      ev_ready = 1'b1; clear_log();
      debounced = 1'b1; step(10);
      debounced = 1'b0; step(10);
      check("t1_count", log_q.size(), 1);
      if (log_q.size() > 0) check("t1_code", int'(log_q[0]), 8'h53);
      check("t1_valid_cycles", valid_cycles, 1);
      check("t1_busy", int'(busy), 0);

      // 2: long press
      clear_log();
      debounced = 1'b1; step(40);
      debounced = 1'b0; step(10);
      n_short = 0;
      foreach (log_q[i]) if (log_q[i] == 8'h53) n_short++;
      check("t2_no_short", n_short, 0);
      if (log_q.size() >= 2) begin
         check("t2_first_long", int'(log_q[0]), 8'h4C);
         check("t2_last_rel", int'(log_q[log_q.size()-1]), 8'h52);
      end else begin
         check("t2_count", log_q.size(), 2);
      end
`ifndef BUTTON_AUTOREPEAT_EN
      check("t2_count", log_q.size(), 2);
`endif

      // 3: slot full, second event dropped
      ev_ready = 1'b0; clear_log();
      debounced = 1'b1; step(6); debounced = 1'b0; step(6);
      debounced = 1'b1; step(6); debounced = 1'b0; step(6);
      check("t3_drops", drop_count, 1);
      check("t3_held_valid", int'(ev_valid), 1);
      check("t3_held_data", int'(ev_data), 8'h53);
      ev_ready = 1'b1; step(5);
      check("t3_consumed", log_q.size(), 1);
      if (log_q.size() > 0) check("t3_code", int'(log_q[0]), 8'h53);

      // 4: release coincides with the deciding tick
      clear_log(); found = 0;
      debounced = 1'b1;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1);
         if (m_pressed && m_ticks == LONG_TICKS - 1 && (m_k % TICK_DIV) == TICK_DIV - 1)
            found = 1;
      end
      check("t4_align_found", int'(found), 1);
      debounced = 1'b0; step(10);
      check("t4_count", log_q.size(), 1);
      if (log_q.size() > 0) check("t4_code", int'(log_q[0]), 8'h53);

      // 5: reset mid-press with an event pending
      ev_ready = 1'b0; clear_log();
      debounced = 1'b1; step(6); debounced = 1'b0; step(6);
      debounced = 1'b1; step(6);
      check("t5_pending", int'(ev_valid), 1);
      reset_n = 1'b0; debounced = 1'b0;
      #1;
      check("t5_rst_valid", int'(ev_valid), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_data", int'(ev_data), 0);
      step(2);
      reset_n = 1'b1; ev_ready = 1'b1; clear_log();
      step(30);
      check("t5_no_events", log_q.size(), 0);

      // 6: long hold, with repeats only when the feature is built in
      clear_log();
      debounced = 1'b1; step(60);
      debounced = 1'b0; step(10);
      n_rep = 0;
      foreach (log_q[i]) if (log_q[i] == 8'h50) n_rep++;
`ifdef BUTTON_AUTOREPEAT_EN
      check("t6_rep_ge2", int'(n_rep >= 2), 1);
      check("t6_count", log_q.size(), n_rep + 2);
      if (log_q.size() >= 3) begin
         check("t6_first_long", int'(log_q[0]), 8'h4C);
         check("t6_last_rel", int'(log_q[log_q.size()-1]), 8'h52);
         for (int i = 1; i < log_q.size() - 1; i++) begin
            check("t6_rep_code", int'(log_q[i]), 8'h50);
            check("t6_rep_spacing", stamp_q[i] - stamp_q[i-1], REPEAT_TICKS * TICK_DIV);
         end
      end
`else
      check("t6_no_rep", n_rep, 0);
      check("t6_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("t6_first_long", int'(log_q[0]), 8'h4C);
         check("t6_last_rel", int'(log_q[1]), 8'h52);
      end
`endif

      // Random presses with a stalling consumer; per-cycle compare does the checking.
      for (int p = 0; p < 60; p++) begin
         int len, gap;
         len = $urandom_range(1, 45);
         gap = $urandom_range(1, 15);
         debounced = 1'b1;
         for (int c = 0; c < len; c++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            step(1);
         end
         debounced = 1'b0;
         for (int c = 0; c < gap; c++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            step(1);
         end
      end
      ev_ready = 1'b1; step(5);
      check("end_idle", int'(busy), 0);
      check("end_empty", int'(ev_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Consumes the clean level from the debouncer FSM and converts press activity into byte-wide event codes: short press, long press, and release-after-long.
Events are presented on a valid/ready interface that feeds the UART TX FIFO write port.
Contains its own millisecond-tick prescaler and press-duration counter.
Includes a one-entry output holding register with overflow reporting.

Parameters:
TICK_DIV, 100000, clk cycles per duration tick (1 ms at 100 MHz); must be >= 2
LONG_TICKS, 500, ticks of continuous press that classify a long press; must be >= 2
REPEAT_TICKS, 200, ticks between repeat events (used only with the optional feature)
SHORT_CODE, 8'h53, event byte for a short press ('S')
LONG_CODE, 8'h4C, event byte for a long press ('L')
REL_CODE, 8'h52, event byte for release after a long press ('R')
REP_CODE, 8'h50, event byte for auto-repeat ('P')

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
debounced  in  1  clean button level from the debouncer; 1 = pressed; synchronous to clk
ev_data  out  8  event byte
ev_valid  out  1  ev_data holds an unconsumed event
ev_ready  in  1  consumer (FIFO write side) accepts ev_data this cycle
ev_drop  out  1  one-cycle pulse: a generated event was discarded because the slot was full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk. During reset:
  - all state goes to IDLE
  - prescaler and ms_cnt = 0
  - ev_valid = 0, ev_data = 8'h00, ev_drop = 0, busy = 0
- Reset asserted mid-press or with an event pending discards everything. No event is emitted after reset deassertion unless a new press starts.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when the count equals TICK_DIV-1.
  - Never cleared except by reset, so the first tick of a press has phase jitter of up to TICK_DIV-1 cycles. This is accepted.
- ms_cnt:
  - Width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1).
  - Cleared on every state entry.
  - Increments on tick and saturates at its maximum.
- FSM states: IDLE, PRESS, LONG_HELD.
  - IDLE: debounced=1 -> PRESS, ms_cnt cleared.
  - PRESS, debounced=0 -> emit SHORT_CODE, go to IDLE. This takes priority over a coincident tick.
  - PRESS, tick and ms_cnt==LONG_TICKS-1 with debounced=1 -> emit LONG_CODE, go to LONG_HELD, ms_cnt cleared.
  - PRESS, otherwise -> stay.
  - LONG_HELD, debounced=0 -> emit REL_CODE, go to IDLE.
  - LONG_HELD, otherwise -> stay.
- A long press therefore yields exactly L then R. A short press yields exactly S.
- Emit: a one-cycle internal strobe with a code, raised in the cycle the FSM takes the transition.
- Output slot:
  - The slot loads when it is empty, or when it is draining in the same cycle (ev_valid & ev_ready).
  - Latency: emit at edge N -> ev_valid=1 with ev_data=code after edge N+1.
  - Back-to-back drain and load: no bubble; ev_valid stays 1 and ev_data changes.
  - Slot full and not draining: the new event is dropped. ev_drop=1 for one cycle; ev_data and ev_valid are unchanged.
  - ev_data is stable while ev_valid & ~ev_ready.
  - ev_valid falls one cycle after acceptance when no new event is loaded.
  - ev_valid does not depend combinationally on ev_ready.
- busy = (state != IDLE), registered-state decode.

Optional Feature:
BUTTON_AUTOREPEAT_EN
- Defined:
  - In LONG_HELD, on tick with ms_cnt==REPEAT_TICKS-1 and debounced=1 -> emit REP_CODE and clear ms_cnt.
  - Release still emits REL_CODE and has priority over a coincident repeat tick.
- Undefined: LONG_HELD ignores ticks, REPEAT_TICKS is unused, and REP_CODE is never produced.

Decomposition:
- Package button_event_pkg holds:
  - state encoding: IDLE=2'd0, PRESS=2'd1, LONG_HELD=2'd2; 2'd3 illegal -> IDLE
  - default event code constants
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, reset_n, tick) is the reusable timer the debouncer also needs.
- The FSM, ms_cnt and output slot stay in the top module.

Test Plan:
All tests use TICK_DIV=4 and LONG_TICKS=5; the auto-repeat test adds REPEAT_TICKS=3.
1. Press for 10 cycles, release, ev_ready=1 -> one event 8'h53; ev_valid high 1 cycle; busy back to 0.
2. Press held for 40 cycles, then release, ev_ready=1 -> 8'h4C during the hold after the 5th tick, then 8'h52 after release; no 8'h53.
3. ev_ready=0, two short presses -> ev_data=8'h53 is held; ev_drop pulses once on the second press; after ev_ready=1, exactly one event is consumed.
4. Release on the same cycle as the 5th tick -> 8'h53 emitted, not 8'h4C.
5. reset_n pulsed low mid-press with a pending event -> ev_valid=0 and busy=0 immediately; no event follows deassertion while debounced stays 0.
6. With BUTTON_AUTOREPEAT_EN, hold for 60 cycles -> 8'h4C, then 8'h50 every 12 cycles, then 8'h52 on release; without the macro -> only 8'h4C and 8'h52.
